// File: rtl/reg_select_unit.sv
// Register-select decoder: decodes Ra/Rb/Rc fields of the held instruction into
// registered one-hot register enables, and sign-extends the immediate field.
module reg_select_unit #(
    parameter int NREG   = 16,
    parameter int IR_W   = 32,
    parameter int RA_LSB = 23,
    parameter int RB_LSB = 19,
    parameter int RC_LSB = 15,
    parameter int C_W    = 19
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [IR_W-1:0] ir_d,
    input  logic            IRin,
    input  logic            Gra,
    input  logic            Grb,
    input  logic            Grc,
    input  logic            Rin,
    input  logic            Rout,
    input  logic            BAout,
    output logic [NREG-1:0] IN,
    output logic [NREG-1:0] OUT,
    output logic            r0_zero,
    output logic [IR_W-1:0] C_ext,
    output logic            sel_err
);

    localparam int FW = $clog2(NREG);

    function automatic logic [IR_W-1:0] sign_ext(input logic [C_W-1:0] imm);
        return {{(IR_W-C_W){imm[C_W-1]}}, imm};
    endfunction

    logic [IR_W-1:0] ir_q;
    logic [NREG-1:0] in_q, in_d, out_q, out_d, dec;
    logic            r0_q, r0_d, err_q, err_d;
    logic [FW-1:0]   ra, rb, rc, sel;
    logic            any_g, multi_g, legal, strobe;
    logic            unused_ir;

    assign ra      = ir_q[RA_LSB +: FW];
    assign rb      = ir_q[RB_LSB +: FW];
    assign rc      = ir_q[RC_LSB +: FW];
    assign any_g   = Gra | Grb | Grc;
    assign multi_g = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
    assign legal   = any_g & ~multi_g;
    assign strobe  = Rin | Rout | BAout;
    assign sel     = ({FW{Gra}} & ra) | ({FW{Grb}} & rb) | ({FW{Grc}} & rc);

    // Decode from the IR held before this edge; a same-cycle IRin only affects later selects.
    always_comb begin
        dec      = '0;
        dec[sel] = 1'b1;
        in_d     = (Rin & legal) ? dec : '0;
        out_d    = ((Rout | BAout) & legal) ? dec : '0;
        r0_d     = BAout & legal & (sel == '0);
        err_d    = err_q | (multi_g & strobe);
    end

    // Stage boundary: enables and error flag become visible one cycle after sampling.
    always_ff @(posedge clock) begin
        if (clear) begin
            ir_q  <= '0;
            in_q  <= '0;
            out_q <= '0;
            r0_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (IRin) ir_q <= ir_d;
            in_q  <= in_d;
            out_q <= out_d;
            r0_q  <= r0_d;
            err_q <= err_d;
        end
    end

    assign IN        = in_q;
    assign OUT       = out_q;
    assign r0_zero   = r0_q;
    assign sel_err   = err_q;
    assign C_ext     = sign_ext(ir_q[C_W-1:0]);
    // Opcode bits above the register fields are carried but not decoded here.
    assign unused_ir = ^ir_q;

endmodule

// File: tb/tb_reg_select_unit.sv
// Directed scoreboard bench for reg_select_unit (16-register default plus a 32-register instance).
module tb_reg_select_unit;

    logic        clock = 1'b0;
    logic        clear, IRin, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [31:0] ir_d;
    logic [15:0] IN, OUT;
    logic        r0_zero, sel_err;
    logic [31:0] C_ext;
    logic [31:0] IN32, OUT32, C_ext32;
    logic        r0_32, err32;

    localparam logic [7:0] CLR = 8'h80, IRI = 8'h40, GA = 8'h20, GB = 8'h10, GC = 8'h08,
                           RIN = 8'h04, ROUT = 8'h02, BA = 8'h01, NONE = 8'h00;

    always #5 clock = ~clock;

    reg_select_unit dut (
        .clock(clock), .clear(clear), .ir_d(ir_d), .IRin(IRin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .IN(IN), .OUT(OUT), .r0_zero(r0_zero), .C_ext(C_ext), .sel_err(sel_err)
    );

    reg_select_unit #(.NREG(32), .RA_LSB(22)) dut32 (
        .clock(clock), .clear(clear), .ir_d(ir_d), .IRin(IRin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .IN(IN32), .OUT(OUT32), .r0_zero(r0_32), .C_ext(C_ext32), .sel_err(err32)
    );

    typedef struct packed {
        logic [15:0] in;
        logic [15:0] out;
        logic        r0;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] ctl, input logic [31:0] ir,
                        input logic [15:0] ein, input logic [15:0] eout,
                        input logic er0, input logic eerr);
        exp_t e;
        {clear, IRin, Gra, Grb, Grc, Rin, Rout, BAout} = ctl;
        ir_d = ir;
        sb.push_back('{in: ein, out: eout, r0: er0, err: eerr});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({tag, ".IN"},      32'(IN),      32'(e.in));
        chk({tag, ".OUT"},     32'(OUT),     32'(e.out));
        chk({tag, ".r0_zero"}, 32'(r0_zero), 32'(e.r0));
        chk({tag, ".sel_err"}, 32'(sel_err), 32'(e.err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        {clear, IRin, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
        ir_d = '0;

        // Reset, and reset overriding a load plus strobe in the same cycle
        step("reset", CLR, 32'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("reset.C_ext", C_ext, 32'h0);
        step("load_a", IRI, 32'h0A8C_0000, 16'h0, 16'h0, 1'b0, 1'b0);
        step("clr_prio", CLR | IRI | GA | RIN, 32'h0A8C_0000, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("clr_prio.C_ext", C_ext, 32'h0);

        // Ra=5, Rb=1, Rc=8; low 19 bits = 0x40000 (negative immediate)
        step("load_b", IRI, 32'h0A8C_0000, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("load_b.C_ext", C_ext, 32'hFFFC_0000);
        step("gra_rin",  GA | RIN,  32'h0, 16'h0020, 16'h0000, 1'b0, 1'b0);
        step("grb_rout", GB | ROUT, 32'h0, 16'h0000, 16'h0002, 1'b0, 1'b0);
        step("grc_rout", GC | ROUT, 32'h0, 16'h0000, 16'h0100, 1'b0, 1'b0);
        step("idle",     NONE,      32'h0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("rin_rout", GA | RIN | ROUT, 32'h0, 16'h0020, 16'h0020, 1'b0, 1'b0);
        step("no_g",     RIN | ROUT,      32'h0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step("g_only",   GA,              32'h0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Base-address read of R0 versus R3
        step("load_rb0", IRI, 32'h0A80_0000, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("load_rb0.C_ext", C_ext, 32'h0);
        step("ba_r0", GB | BA, 32'h0, 16'h0000, 16'h0001, 1'b1, 1'b0);
        step("load_rb3", IRI, 32'h0A98_0000, 16'h0, 16'h0, 1'b0, 1'b0);
        step("ba_r3", GB | BA, 32'h0, 16'h0000, 16'h0008, 1'b0, 1'b0);

        // Illegal select, sticky error, clear during active strobe
        step("illegal", GA | GB | RIN, 32'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            step("err_hold", NONE, 32'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        step("clr_strobe", CLR | GA | RIN, 32'h0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Load and select in one cycle decode the old IR
        step("load_c", IRI, 32'h0A8C_0000, 16'h0, 16'h0, 1'b0, 1'b0);
        step("ld_and_sel", IRI | GA | RIN, 32'h0104_0000, 16'h0020, 16'h0, 1'b0, 1'b0);
        step("new_ra", GA | RIN, 32'h0, 16'h0004, 16'h0, 1'b0, 1'b0);
        chk("new_ra.C_ext", C_ext, 32'hFFFC_0000);

        // 32-register instance: Ra=17 at LSB 22 (default instance sees Ra=8 at LSB 23)
        step("load_32", IRI, 32'h0440_0000, 16'h0, 16'h0, 1'b0, 1'b0);
        step("gra_rin32", GA | RIN, 32'h0, 16'h0100, 16'h0, 1'b0, 1'b0);
        chk("n32.IN",      IN32,            32'h0002_0000);
        chk("n32.OUT",     OUT32,           32'h0);
        chk("n32.C_ext",   C_ext32,         32'h0);
        chk("n32.r0_zero", 32'(r0_32),      32'h0);
        chk("n32.sel_err", 32'(err32),      32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
